// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if -- bundles the request, serial and result signals of the
// SPI master controller.
//   master : controller side (takes start/nbytes/tx_data/miso, drives the rest)
//   slave  : user/testbench side (mirror image)
interface spi_master_ctrl_if;
  logic        start;
  logic [1:0]  nbytes;
  logic [31:0] tx_data;
  logic        miso;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;
  logic        sclk;
  logic        mosi;
  logic        cs_n;

  modport master (
    input  start, nbytes, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, cs_n
  );

  modport slave (
    output start, nbytes, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl -- SPI mode-0 master, 1..4 byte transfers, MSB first.
// Ports:
//   clk, rst     : system clock (rising edge), asynchronous active-high reset
//   bus.start    : request a transfer (ignored while busy)
//   bus.nbytes   : byte count minus one, latched with start
//   bus.tx_data  : transmit word, low 8*(nbytes+1) bits sent
//   bus.miso     : serial input from the slave
//   bus.busy     : high in SETUP/SHIFT/HOLD
//   bus.done     : one-cycle pulse when the transfer finishes
//   bus.rx_data  : received word, right-justified
//   bus.sclk/mosi/cs_n : SPI pins
// Parameter CLK_DIV: clk cycles per SCLK half-period (1..255).
// Macro SPI_RX_EN: when defined, miso is sampled into an RX register and
// reported on rx_data; otherwise rx_data is tied to zero.
module spi_master_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.master bus
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_e;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [1:0]  nbytes_q, nbytes_d;
  logic        last_q, last_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef SPI_RX_EN
  logic [31:0] rx_sr_q, rx_sr_d;
  logic [31:0] rx_data_q, rx_data_d;
`endif

  logic        div_hit;
  logic [31:0] tx_aligned;

  assign div_hit = (div_q == DIV_LAST);
  // 3-nbytes on a 2-bit field is just ~nbytes; left-justify the payload.
  assign tx_aligned = bus.tx_data << {~bus.nbytes, 3'b000};

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    nbytes_d   = nbytes_q;
    last_d     = last_q;
    tx_sr_d    = tx_sr_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef SPI_RX_EN
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d    = SETUP;
          nbytes_d   = bus.nbytes;
          tx_sr_d    = tx_aligned;
          mosi_d     = tx_aligned[31];
          div_d      = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          last_d     = 1'b0;
          cs_n_d     = 1'b0;
          busy_d     = 1'b1;
`ifdef SPI_RX_EN
          rx_sr_d    = '0;
`endif
        end
      end
      SETUP: begin
        div_d = div_q + 8'd1;
        if (div_hit) begin
          div_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        div_d = div_q + 8'd1;
        if (div_hit) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // rising edge: sample, count, and flag the final bit
`ifdef SPI_RX_EN
            rx_sr_d = {rx_sr_q[30:0], bus.miso};
`endif
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_cnt_d = byte_cnt_q + 2'd1;
            last_d = (byte_cnt_q == nbytes_q) && (bit_cnt_q == 3'd7);
          end else if (last_q) begin
            state_d = HOLD;
          end else begin
            tx_sr_d = {tx_sr_q[30:0], 1'b0};
            mosi_d  = tx_sr_q[30];
          end
        end
      end
      HOLD: begin
        div_d = div_q + 8'd1;
        if (div_hit) begin
          div_d   = '0;
          state_d = DONE;
          done_d  = 1'b1;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          mosi_d  = 1'b0;
`ifdef SPI_RX_EN
          rx_data_d = rx_sr_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      nbytes_q   <= '0;
      last_q     <= 1'b0;
      tx_sr_q    <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef SPI_RX_EN
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      nbytes_q   <= nbytes_d;
      last_q     <= last_d;
      tx_sr_q    <= tx_sr_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef SPI_RX_EN
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
`endif
    end
  end

  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;
  assign bus.cs_n = cs_n_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef SPI_RX_EN
  assign bus.rx_data = rx_data_q;
`else
  assign bus.rx_data = '0;
`endif
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl -- checks spi_master_ctrl at CLK_DIV=2 (table of directed
// and random transfers, mid-transfer restart, mid-transfer reset) and at
// CLK_DIV=1 (start held high, back-to-back transfers).
module tb_spi_master_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_master_ctrl_if if2();
  spi_master_ctrl_if if1();

  logic miso_drv = 1'b0;
  logic loop2 = 1'b0;
  assign if2.miso = loop2 ? if2.mosi : miso_drv;
  assign if1.miso = if1.mosi;

  spi_master_ctrl #(.CLK_DIV(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.master));
  spi_master_ctrl #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.master));

`ifdef SPI_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt2 = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (if2.done) done_cnt2 <= done_cnt2 + 1;

  typedef struct {
    logic [1:0]  nb;
    logic [31:0] tx;
    logic [31:0] mw;      // word presented on miso, MSB of the used field first
    bit          loop;    // miso looped back from mosi
    bit          restart; // pulse start again mid-transfer
    int          edges;
    logic [31:0] mosi;
    logic [31:0] rx;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask(input logic [1:0] nb);
    logic [63:0] m;
    m = (64'd1 << (8 * (int'(nb) + 1))) - 64'd1;
    return m[31:0];
  endfunction

  // Reference: a transfer of nb+1 bytes sends the low bytes of tx MSB first,
  // receives the same number of bits, and completes after 2+16*(nb+1)
  // half-periods of CLK_DIV=2 cycles.
  function automatic vec_t model(input logic [1:0] nb, input logic [31:0] tx,
                                 input logic [31:0] mw, input bit loop);
    vec_t v;
    v.nb = nb; v.tx = tx; v.mw = mw; v.loop = loop; v.restart = 1'b0;
    v.edges = 8 * (int'(nb) + 1);
    v.mosi  = tx & mask(nb);
    v.rx    = RX_EN ? ((loop ? tx : mw) & mask(nb)) : 32'h0;
    v.lat   = 2 * (2 + 16 * (int'(nb) + 1));
    return v;
  endfunction

  task automatic run2(input vec_t v, input string tag);
    int edges, acc, dlat, rs, extra_done, cs_low, rx_chg, nbits;
    logic [31:0] cap, rxv;
    bit prev_sclk, seen;
    edges = 0; cap = '0; dlat = -1; rs = 0; seen = 1'b0; rxv = '0;
    nbits = 8 * (int'(v.nb) + 1);
    @(posedge clk); #1;
    if2.start = 1'b1; if2.nbytes = v.nb; if2.tx_data = v.tx; loop2 = v.loop;
    miso_drv = v.mw[nbits-1];
    acc = cyc + 1;
    @(posedge clk); #1;
    if2.start = 1'b0; if2.tx_data = $urandom; if2.nbytes = 2'($urandom);
    check({tag, "_busy"}, {63'd0, if2.busy}, 64'd1);
    prev_sclk = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (if2.sclk && !prev_sclk) begin
        cap = {cap[30:0], if2.mosi};
        edges++;
        if (edges < nbits) miso_drv = v.mw[nbits-1-edges];
      end
      prev_sclk = if2.sclk;
      if (v.restart && edges == 5 && rs == 0) begin
        if2.start = 1'b1; if2.nbytes = 2'd3; if2.tx_data = 32'hFFFF_FFFF; rs = 1;
      end else if (rs == 1) begin
        if2.start = 1'b0; rs = 2;
      end
      if (if2.done) begin
        seen = 1'b1; dlat = cyc - acc; rxv = if2.rx_data;
        check({tag, "_cs_n_at_done"}, {63'd0, if2.cs_n}, 64'd1);
      end
    end
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_latency"}, 64'(dlat), 64'(v.lat));
    check({tag, "_edges"}, 64'(edges), 64'(v.edges));
    check({tag, "_mosi"}, {32'd0, cap & mask(v.nb)}, {32'd0, v.mosi});
    check({tag, "_rx"}, {32'd0, rxv}, {32'd0, v.rx});
    extra_done = 0; cs_low = 0; rx_chg = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if2.done) extra_done++;
      if (!if2.cs_n) cs_low++;
      if (if2.rx_data !== rxv) rx_chg++;
    end
    check({tag, "_extra_done"}, 64'(extra_done), 64'd0);
    check({tag, "_idle_cs_low"}, 64'(cs_low), 64'd0);
    check({tag, "_rx_stable"}, 64'(rx_chg), 64'd0);
    check({tag, "_idle_pins"}, {61'd0, if2.sclk, if2.mosi, if2.busy}, 64'd0);
  endtask

  initial begin
    vec_t v;
    int edges, dc0, hi_run, bad_runs, txns, dones, last_done, bad_gap, e1, bad_edges, first_lat, acc1;
    bit prev_sc, prev_cs;
    if2.start = 1'b0; if2.nbytes = '0; if2.tx_data = '0;
    if1.start = 1'b0; if1.nbytes = '0; if1.tx_data = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cs_n", {63'd0, if2.cs_n}, 64'd1);
    check("rst_pins", {61'd0, if2.sclk, if2.mosi, if2.busy}, 64'd0);
    check("rst_done", {63'd0, if2.done}, 64'd0);
    check("rst_rx", {32'd0, if2.rx_data}, 64'd0);
    check("rst_cs_n_div1", {63'd0, if1.cs_n}, 64'd1);
    rst = 1'b0;

    // directed vectors with hand-derived expectations
    v = '{nb: 2'd0, tx: 32'h0000_00A5, mw: 32'h0, loop: 1'b1, restart: 1'b0, edges: 8,
          mosi: 32'h0000_00A5, rx: RX_EN ? 32'h0000_00A5 : 32'h0, lat: 36};
    vecs.push_back(v);
    v = '{nb: 2'd3, tx: 32'hDEAD_BEEF, mw: 32'hFFFF_FFFF, loop: 1'b0, restart: 1'b0, edges: 32,
          mosi: 32'hDEAD_BEEF, rx: RX_EN ? 32'hFFFF_FFFF : 32'h0, lat: 132};
    vecs.push_back(v);
    v = '{nb: 2'd1, tx: 32'h1234_5678, mw: 32'h0000_A55A, loop: 1'b0, restart: 1'b1, edges: 16,
          mosi: 32'h0000_5678, rx: RX_EN ? 32'h0000_A55A : 32'h0, lat: 68};
    vecs.push_back(v);
    v = '{nb: 2'd2, tx: 32'hFF12_3456, mw: 32'h00C3_C3C3, loop: 1'b0, restart: 1'b0, edges: 24,
          mosi: 32'h0012_3456, rx: RX_EN ? 32'h00C3_C3C3 : 32'h0, lat: 100};
    vecs.push_back(v);
    for (int i = 0; i < 8; i++)
      vecs.push_back(model(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1))));

    foreach (vecs[i]) run2(vecs[i], $sformatf("vec%0d", i));

    // reset during the second byte of a 4-byte transfer
    @(posedge clk); #1;
    if2.start = 1'b1; if2.nbytes = 2'd3; if2.tx_data = $urandom; loop2 = 1'b0; miso_drv = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0;
    dc0 = done_cnt2; edges = 0; prev_sc = 1'b0;
    for (int i = 0; i < 400 && edges < 12; i++) begin
      @(negedge clk);
      if (if2.sclk && !prev_sc) edges++;
      prev_sc = if2.sclk;
    end
    check("rstmid_reached", 64'(edges), 64'd12);
    check("rstmid_cs_low_before", {63'd0, if2.cs_n}, 64'd0);
    #2 rst = 1'b1;
    #1;
    check("rstmid_async_cs_n", {63'd0, if2.cs_n}, 64'd1);
    check("rstmid_async_pins", {61'd0, if2.sclk, if2.mosi, if2.busy}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_done", 64'(done_cnt2 - dc0), 64'd0);
    check("rstmid_rx_cleared", {32'd0, if2.rx_data}, 64'd0);
    run2(model(2'd0, 32'h0000_003C, 32'h0, 1'b1), "post_rst");

    // CLK_DIV=1, start held high: one cs_n-high cycle between transfers
    @(posedge clk); #1;
    if1.start = 1'b1; if1.nbytes = 2'd0; if1.tx_data = 32'h0000_00C3;
    acc1 = cyc + 1;
    hi_run = 0; bad_runs = 0; txns = 0; dones = 0; last_done = -1; bad_gap = 0;
    e1 = 0; bad_edges = 0; first_lat = -1; prev_sc = 1'b0; prev_cs = 1'b1;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (i == 100) if1.start = 1'b0;
      if (if1.sclk && !prev_sc) e1++;
      prev_sc = if1.sclk;
      if (!if1.cs_n && prev_cs) begin
        if (txns > 0 && hi_run != 1) bad_runs++;
        txns++;
      end
      if (if1.cs_n) hi_run++; else hi_run = 0;
      prev_cs = if1.cs_n;
      if (if1.done) begin
        dones++;
        if (e1 != 8) bad_edges++;
        e1 = 0;
        if (last_done < 0) first_lat = cyc - acc1;
        else if (cyc - last_done != 19) bad_gap++;
        last_done = cyc;
      end
    end
    check("b2b_first_latency", 64'(first_lat), 64'd18);
    check("b2b_min_txns", {63'd0, txns >= 5}, 64'd1);
    check("b2b_done_per_txn", 64'(dones), 64'(txns));
    check("b2b_cs_gap", 64'(bad_runs), 64'd0);
    check("b2b_done_period", 64'(bad_gap), 64'd0);
    check("b2b_edges", 64'(bad_edges), 64'd0);
    check("b2b_rx", {32'd0, if1.rx_data}, RX_EN ? 64'h0C3 : 64'h0);
    check("b2b_idle", {60'd0, if1.cs_n, if1.busy, if1.sclk, if1.done}, 64'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
